multiport_program_memory: RTL and testbench

MULTIPORT_PROGRAM_MEMORY -- requirements
Module: multiport_program_memory

---
 rtl/multiport_program_memory.sv | 126 ++++++++++++
 tb/tb_multiport_program_memory.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multiport_program_memory.sv
// ============================================================================
//  Module   : multiport_program_memory
//  Purpose  : Clear, load and then serve a program image on NUM_PORTS read ports
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multiport_program_memory #(
  parameter int                NUM_PORTS = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'h70
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ADDR_W-1:0]           load_addr,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_last,
  output logic [ADDR_W:0]             load_count,
  input  logic [NUM_PORTS-1:0]        rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic                        busy
);

  localparam int c_DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                    state_q;
  logic [ADDR_W-1:0]         clr_addr_q;
  logic [ADDR_W:0]           load_count_q;
  logic [DATA_W-1:0]         mem_q [c_DEPTH];
  logic [NUM_PORTS-1:0]      rd_valid_q;
  logic [NUM_PORTS*DATA_W-1:0] rd_data_q;

  logic                      w_load_accept;
  logic                      w_mem_we;
  logic [ADDR_W-1:0]         w_mem_waddr;
  logic [DATA_W-1:0]         w_mem_wdata;

  // Reset gates the handshake so a reset arriving mid-LOAD blocks the write at once.
  assign load_ready    = (state_q == S_LOAD) && !reset;
  assign busy          = (state_q != S_RUN) || reset;
  assign w_load_accept = load_valid && load_ready;
  assign load_count    = load_count_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = clr_addr_q;
    w_mem_wdata = FILL_WORD;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        w_mem_we = 1'b1;
      end else if (w_load_accept) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = load_addr;
        w_mem_wdata = load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      load_count_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR_W{1'b1}}) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_load_accept) begin
            if (load_count_q != (ADDR_W+1)'(c_DEPTH)) begin
              load_count_q <= load_count_q + 1'b1;
            end
            if (load_last) begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Every port reads independently each cycle; data holds while a port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((state_q == S_RUN) && rd_req[i]) begin
          rd_valid_q[i]                  <= 1'b1;
          rd_data_q[i*DATA_W +: DATA_W]  <= mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
        end else begin
          rd_valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multiport_program_memory.sv
// ============================================================================
//  Module   : tb_multiport_program_memory
//  Purpose  : Directed vector bench for multiport_program_memory
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiport_program_memory;

  localparam int NP = 8;
  localparam int AW = 8;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [AW-1:0]    load_addr;
  logic [DW-1:0]    load_data;
  logic             load_last;
  logic [AW:0]      load_count;
  logic [NP-1:0]    rd_req;
  logic [NP*AW-1:0] rd_addr;
  logic [NP-1:0]    rd_valid;
  logic [NP*DW-1:0] rd_data;
  logic             busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  req;
    logic [63:0] addr;
    logic [7:0]  exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl [7];

  multiport_program_memory #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .FILL_WORD(8'h70)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .load_count(load_count),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts cycles until load_ready rises, watching busy and rd_valid meanwhile.
  task automatic wait_clear(input string nm);
    int   n = 0;
    logic ok = 1'b1;
    while (!load_ready && n < 300) begin
      if (!busy || rd_valid != '0) ok = 1'b0;
      tick();
      n++;
    end
    chk({nm, "_clear_len"}, 64'(n), 64'd256);
    chk({nm, "_busy_during_clear"}, 64'(ok), 64'd1);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h01, 64'h0000000000000002, 8'h01, 64'h8080808080808098};
    tbl[1] = '{8'h01, 64'h00000000000000C8, 8'h01, 64'h8080808080808070};
    tbl[2] = '{8'hFF, 64'h0303030303030303, 8'hFF, 64'h9C9C9C9C9C9C9C9C};
    tbl[3] = '{8'h00, 64'h0303030303030303, 8'h00, 64'h9C9C9C9C9C9C9C9C};
    tbl[4] = '{8'hA5, 64'h0706050403020100, 8'hA5, 64'h709C709C9C989C80};
    tbl[5] = '{8'h5A, 64'hFFFFFFFFFFFFFFFF, 8'h5A, 64'h7070707070987080};
    tbl[6] = '{8'h80, 64'h0100000000000000, 8'h80, 64'h0870707070987080};

    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
    rd_req = 8'hFF; rd_addr = '0;
    tick(); tick();
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_busy",       64'(busy),       64'd1);
    chk("rst_load_count", 64'(load_count), 64'd0);
    chk("rst_rd_valid",   64'(rd_valid),   64'd0);
    chk("rst_rd_data",    rd_data,         64'd0);

    // Basic image with reads requested on every port throughout clear and load
    reset = 1'b0;
    wait_clear("t1");
    chk("t1_count_after_clear", 64'(load_count), 64'd0);
    load_word(8'd0, 8'h80, 1'b0);
    load_word(8'd1, 8'h08, 1'b0);
    load_last = 1'b1;
    tick();
    load_last = 1'b0;
    chk("last_without_valid", 64'(load_ready), 64'd1);
    chk("no_read_in_load", 64'(rd_valid), 64'd0);
    load_word(8'd2, 8'h98, 1'b0);
    load_word(8'd3, 8'h9C, 1'b1);
    chk("no_serve_last_cycle", 64'(rd_valid), 64'd0);
    chk("t1_count", 64'(load_count), 64'd4);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_load_ready", 64'(load_ready), 64'd0);
    tick();
    chk("first_run_valid", 64'(rd_valid), 64'hFF);
    chk("first_run_data", rd_data, 64'h8080808080808080);

    for (int i = 0; i < 7; i++) begin
      rd_req  = tbl[i].req;
      rd_addr = tbl[i].addr;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_data", i), rd_data, tbl[i].exp_data);
    end

    // Loader traffic in RUN must not write
    rd_req = 8'h00;
    load_valid = 1'b1; load_addr = 8'd2; load_data = 8'hEE; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("run_ignore_count", 64'(load_count), 64'd4);
    rd_req = 8'h01; rd_addr = 64'h2;
    tick();
    chk("run_ignore_data", rd_data, 64'h0870707070987098);

    reset = 1'b1; rd_req = 8'h00;
    tick();
    chk("run_rst_data",  rd_data, 64'd0);
    chk("run_rst_valid", 64'(rd_valid), 64'd0);
    chk("run_rst_busy",  64'(busy), 64'd1);

    // Last write wins
    reset = 1'b0;
    wait_clear("t44");
    load_word(8'd7, 8'h11, 1'b0);
    load_word(8'd7, 8'h22, 1'b1);
    chk("t44_count", 64'(load_count), 64'd2);
    rd_req = 8'h01; rd_addr = 64'h7;
    tick();
    chk("t44_valid", 64'(rd_valid), 64'h01);
    chk("t44_data",  64'(rd_data[7:0]), 64'h22);

    // Loader active during clear, reset mid-load, reload
    rd_req = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_valid = 1'b1; load_addr = 8'd0; load_data = 8'hAA;
    wait_clear("t43a");
    chk("t43_clear_ignores_load", 64'(load_count), 64'd0);
    tick();
    load_addr = 8'd1; load_data = 8'hBB;
    tick();
    load_valid = 1'b0;
    chk("t43_two_words", 64'(load_count), 64'd2);
    reset = 1'b1;
    #1;
    chk("t43_ready_in_reset", 64'(load_ready), 64'd0);
    tick();
    chk("t43_count_cleared", 64'(load_count), 64'd0);
    reset = 1'b0;
    wait_clear("t43b");
    load_word(8'd5, 8'h33, 1'b1);
    rd_req = 8'h0F; rd_addr = 64'h0000000009050100;
    tick();
    chk("t43_valid", 64'(rd_valid), 64'h0F);
    chk("t43_data",  rd_data, 64'h0000000070337070);

    // Count saturates at DEPTH
    rd_req = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear("sat");
    for (int i = 0; i < 257; i++) begin
      load_word(8'(i), 8'h70, 1'b0);
    end
    chk("sat_count", 64'(load_count), 64'd256);
    chk("sat_still_load", 64'(load_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
